display_scan_ctrl: RTL

Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display. Accepts a 16-bit hex/BCD value plus decimal points through a load handshake. Double-buffers the value so it changes only at frame boundaries, with no tearing. Walks the four anodes at a fixed refresh rate and feeds the active nibble through the shared hex-to-segment decoder.

---
 rtl/sseg_pkg.sv | 24 ++
 rtl/hex_to_sseg.sv | 17 +
 rtl/display_scan_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants and types for the 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [0:6] seg_t;          // [0] = segment a ... [6] = segment g

    localparam seg_t       SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low segment patterns for hex digits 0..F
    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_sseg
// Description : Combinational hex nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : 4-digit multiplexed 7-segment scanner with frame-aligned
//               double buffering and leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_en,
    output logic        pending,
    output logic        ack,
    output logic [0:6]  SSeg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int               PW           = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]    c_presc_last = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]    c_blank_end  = PW'(BLANK_CYCLES);

    logic [PW-1:0] r_presc;
    digit_idx_t    r_idx;
    logic [15:0]   r_shadow;
    logic [3:0]    r_shadow_dp;
    logic [15:0]   r_disp;
    logic [3:0]    r_disp_dp;
    logic          r_pending;
    logic          r_ack;
    seg_t          r_sseg;
    logic          r_dp;
    logic [3:0]    r_an;

    logic          w_tick;
    logic          w_commit;
    logic [3:0]    w_nibble;
    logic          w_lz_blank;
    seg_t          w_dec_seg;
    seg_t          w_seg_nxt;
    logic          w_dp_nxt;
    logic [3:0]    w_an_nxt;

    assign w_tick   = (r_presc == c_presc_last);
    // Commit only at the frame boundary so a value is never split across digits
    assign w_commit = en && w_tick && (r_idx == 2'd3) && r_pending;
    assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];

    hex_to_sseg u_dec (
        .nibble (w_nibble),
        .seg    (w_dec_seg)
    );

    // A digit is a leading zero when it and every digit to its left is zero
    always_comb begin
        w_lz_blank = 1'b0;
        if (lz_en) begin
            case (r_idx)
                2'd3:    w_lz_blank = (r_disp[15:12] == 4'h0);
                2'd2:    w_lz_blank = (r_disp[15:8]  == 8'h00);
                2'd1:    w_lz_blank = (r_disp[15:4]  == 12'h000);
                default: w_lz_blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = 1'b1;
        if (en && (r_presc >= c_blank_end)) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_lz_blank ? SEG_BLANK : w_dec_seg;
            w_dp_nxt  = ~r_disp_dp[r_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc     <= '0;
            r_idx       <= 2'd0;
            r_shadow    <= 16'h0000;
            r_shadow_dp <= 4'h0;
            r_disp      <= 16'h0000;
            r_disp_dp   <= 4'h0;
            r_pending   <= 1'b0;
            r_ack       <= 1'b0;
            r_sseg      <= SEG_BLANK;
            r_dp        <= 1'b1;
            r_an        <= AN_OFF;
        end else begin
            if (en) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_idx   <= r_idx + 2'd1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (w_commit) begin
                r_disp    <= r_shadow;
                r_disp_dp <= r_shadow_dp;
            end

            // A load on the commit cycle wins over the pending clear
            if (load) begin
                r_shadow    <= data_in;
                r_shadow_dp <= dp_in;
                r_pending   <= 1'b1;
            end else if (w_commit) begin
                r_pending   <= 1'b0;
            end

            r_ack  <= w_commit;
            r_sseg <= w_seg_nxt;
            r_dp   <= w_dp_nxt;
            r_an   <= w_an_nxt;
        end
    end

    assign pending = r_pending;
    assign ack     = r_ack;
    assign SSeg    = r_sseg;
    assign dp      = r_dp;
    assign an      = r_an;

endmodule
`default_nettype wire
